// File: rtl/gpio_pkg.sv
// Shared defaults and helpers for the GPIO input conditioner.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH    = 32;
  localparam int unsigned GPIO_TICK_DIV = 50000;
  localparam int unsigned GPIO_DB_TICKS = 10;

  typedef enum logic [1:0] {
    DB_HOLD,
    DB_CLEAR,
    DB_COUNT,
    DB_ACCEPT
  } db_action_e;

  function automatic int unsigned db_cnt_width(input int unsigned db_ticks);
    return $clog2(db_ticks + 1);
  endfunction

  function automatic int unsigned pre_cnt_width(input int unsigned tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/gpio_bit_debounce.sv
// One GPIO bit: two-flop synchronizer, tick-based debounce counter, clean level
// and optional registered edge pulses (GPIO_EDGE_EN).
module gpio_bit_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DB_TICKS = GPIO_DB_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
`ifdef GPIO_EDGE_EN
  ,
  output logic accept
`endif
);

  localparam int unsigned     CW       = db_cnt_width(DB_TICKS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_TICKS - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  db_action_e    action;

  // Any cycle where the synchronized level matches clean restarts the count.
  always_comb begin
    action = DB_HOLD;
    if (sync2 == clean) begin
      action = DB_CLEAR;
    end else if (tick) begin
      action = (cnt == CNT_LAST) ? DB_ACCEPT : DB_COUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      unique case (action)
        DB_CLEAR:  cnt <= '0;
        DB_COUNT:  cnt <= cnt + CW'(1);
        DB_ACCEPT: begin
          cnt   <= '0;
          clean <= sync2;
        end
        default:   cnt <= cnt;
      endcase
    end
  end

`ifdef GPIO_EDGE_EN
  assign accept = (action == DB_ACCEPT);

  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & sync2;
      fall <= accept & ~sync2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions raw GPIO header inputs: synchronize, debounce on a shared tick,
// and (when GPIO_EDGE_EN is defined) emit RISE/FALL/CHANGED pulses.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH    = GPIO_WIDTH,
  parameter int unsigned TICK_DIV = GPIO_TICK_DIV,
  parameter int unsigned DB_TICKS = GPIO_DB_TICKS
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic [WIDTH-1:0] GPIO_IN,
  output logic [WIDTH-1:0] CLEAN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHANGED
);

  localparam int unsigned   PW       = pre_cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;
  logic          tick;

  // With TICK_DIV=1 the counter sits at 0 and tick stays high.
  assign tick = (pre == PRE_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      pre <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

`ifdef GPIO_EDGE_EN
  logic [WIDTH-1:0] accept;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_debounce #(
      .DB_TICKS(DB_TICKS)
    ) u_bit (
      .clk   (CLOCK_50),
      .rst   (Reset),
      .tick  (tick),
      .raw   (GPIO_IN[i]),
      .clean (CLEAN[i]),
      .rise  (RISE[i]),
      .fall  (FALL[i])
`ifdef GPIO_EDGE_EN
      ,
      .accept(accept[i])
`endif
    );
  end

`ifdef GPIO_EDGE_EN
  // Registered from the same accept strobes as RISE/FALL so all three align.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      CHANGED <= 1'b0;
    end else begin
      CHANGED <= |accept;
    end
  end
`else
  assign CHANGED = 1'b0;
`endif

endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Conditions raw DE-series 40-pin header inputs before any display or control logic consumes them. Per bit, it provides:
- a two-flop synchronizer;
- a tick-based debouncer;
- registered rise/fall edge pulses.

It sits directly downstream of the `GPIO` inout pins, where the top level drives `GPIO` to high-Z, and upstream of HEX segment drivers or any counter logic that needs clean, glitch-free levels.

## Interface
- `WIDTH`, 32: number of conditioned GPIO bits.
- `TICK_DIV`, 50000: clock cycles per debounce tick (1 ms at 50 MHz); must be ≥1.
- `DB_TICKS`, 10: consecutive differing ticks required to accept a new level; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `CLOCK_50`  input  1  system clock; all state updates on its rising edge.
- `Reset`  input  1  synchronous, active-high reset.
- `GPIO_IN`  input  WIDTH  raw, asynchronous header levels.
- `CLEAN`  output  WIDTH  debounced levels.
- `RISE`  output  WIDTH  one-cycle pulse per bit on a CLEAN 0→1 transition.
- `FALL`  output  WIDTH  one-cycle pulse per bit on a CLEAN 1→0 transition.
- `CHANGED`  output  1  one-cycle pulse when any bit of RISE|FALL is set.

## Operation
- **Synchronizer:**
  - `sync1 <= GPIO_IN; sync2 <= sync1` every cycle.
  - Only `sync2` feeds the debouncer.
- **Prescaler:**
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - `tick` is high in the cycle where the count equals TICK_DIV-1.
  - With TICK_DIV=1, `tick` is constantly 1.
- **Per-bit debounce counter:** width $clog2(DB_TICKS+1). Update rules per cycle:
  - `sync2 == CLEAN`: counter cleared to 0, whether or not `tick` is high. This is the glitch rejection.
  - `sync2 != CLEAN`, `tick` high, counter < DB_TICKS-1: counter increments.
  - `sync2 != CLEAN`, `tick` high, counter == DB_TICKS-1: `CLEAN <= sync2`, counter <= 0.
  - `sync2 != CLEAN`, `tick` low: counter holds.
- **Edge pulses:**
  - In the cycle `CLEAN` updates, RISE or FALL for that bit is registered high for exactly one cycle.
  - CHANGED is registered alongside as the OR-reduce.
  - All other cycles: 0.
- Bits are fully independent. Any number of bits may flip in the same cycle, with pulses asserted together.

## Timing
- **Reset values:** `sync1`, `sync2`, `CLEAN`, RISE, FALL, CHANGED, prescaler and all debounce counters are 0. Reset overrides all other updates in the same cycle.
- **Latency (TICK_DIV=1):**
  - A stable raw change is seen on `sync2` after 2 edges.
  - `CLEAN`, RISE/FALL and CHANGED update at edge DB_TICKS+2.
- **Latency (TICK_DIV>1):** between 2+(DB_TICKS-1)·TICK_DIV+1 and 2+DB_TICKS·TICK_DIV cycles, depending on prescaler phase.
- **Glitch rejection:** a raw pulse shorter than DB_TICKS ticks at `sync2` never reaches `CLEAN`.
- **Reset mid-count:** pending counts are discarded. After release, the full latency applies again, measured from the first post-reset cycle.
- **Input equal to CLEAN at a tick:** counter cleared, no increment.

## Configuration
- Macro: `GPIO_EDGE_EN`.
- Defined: RISE, FALL and CHANGED behave as specified above.
- Undefined: edge registers are not built; RISE, FALL and CHANGED are tied to 0. `CLEAN` timing is unchanged.

## Structure
- Package `gpio_pkg` holds:
  - default constants `GPIO_WIDTH` = 32, `GPIO_TICK_DIV` = 50000, `GPIO_DB_TICKS` = 10;
  - a function returning the counter width for a given DB_TICKS.
- Sub-module `gpio_bit_debounce` contains one bit's synchronizer, counter, `CLEAN` flop and edge flops, with `tick` as an input.
- The top generates WIDTH instances, one shared prescaler, and the CHANGED OR-reduce.

## Test plan
Unless a scenario states otherwise: TICK_DIV=1, DB_TICKS=4, `GPIO_EDGE_EN` defined.
- **Reset:** hold Reset 3 cycles with GPIO_IN=0xFFFF_FFFF → all outputs 0 during reset. Then CLEAN=0xFFFF_FFFF 6 edges after release, with RISE=0xFFFF_FFFF and CHANGED=1 for one cycle.
- **Single bit:** GPIO_IN 0x0→0x1 held → CLEAN[0]=1 at edge 6, RISE=0x1 and CHANGED=1 for exactly one cycle, FALL=0.
- **Glitch:** GPIO_IN[5] high for 3 cycles then low → CLEAN, RISE, FALL and CHANGED stay 0 throughout.
- **Simultaneous events:** from CLEAN=0x1, change GPIO_IN to 0x8000_0000 in one cycle → at edge 6, CLEAN=0x8000_0000, RISE=0x8000_0000, FALL=0x1, CHANGED=1 for one cycle.
- **Reset mid-count:** raise GPIO_IN[0], pulse Reset at edge 4 → CLEAN[0] stays 0 through edge 4, then becomes 1 exactly 6 edges after Reset deasserts.
- **Macro off:** build without `GPIO_EDGE_EN` and rerun the single-bit scenario → CLEAN[0]=1 at edge 6, while RISE, FALL and CHANGED remain 0 throughout.
